// File: rtl/mmio_game_regs.sv
// Memory-mapped game register block: key-event FIFO, status/commit control and
// double-buffered object coordinates/score that only change on a vertical-sync frame tick.
module mmio_game_regs #(
  parameter logic [11:0] BASE_ADDR  = 12'd2000,
  parameter int          NUM_OBJ    = 4,
  parameter int          COORD_W    = 10,
  parameter int          X_INIT     = 315,
  parameter int          Y_INIT     = 235,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [11:0]                  addr,
  input  logic [31:0]                  wdata,
  input  logic                         wren,
  output logic [31:0]                  rdata,
  output logic                         hit,
  input  logic                         key_valid,
  input  logic [7:0]                   key_data,
  input  logic                         vsync_n,
  output logic [NUM_OBJ*COORD_W-1:0]   obj_x,
  output logic [NUM_OBJ*COORD_W-1:0]   obj_y,
  output logic [7:0]                   score
);

  localparam int NREG  = 3 + 2 * NUM_OBJ;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [12:0] addr_ext;
  logic [11:0] off;
  logic        wr_key, wr_status;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               not_empty, full, pop, push, ovf_event;
  logic [7:0]         head;

  logic               sync1_q, sync2_q, sync3_q, frame_tick, commit;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               ovf_q, ovf_d, pend_q, pend_d;

  logic [COORD_W-1:0] shx_q [NUM_OBJ], shx_d [NUM_OBJ], shy_q [NUM_OBJ], shy_d [NUM_OBJ];
  logic [COORD_W-1:0] actx_q [NUM_OBJ], actx_d [NUM_OBJ], acty_q [NUM_OBJ], acty_d [NUM_OBJ];
  logic [7:0]         shs_q, shs_d, acts_q, acts_d;
  logic               unused_wdata;

  assign addr_ext  = {1'b0, addr};
  assign hit       = (addr_ext >= {1'b0, BASE_ADDR}) &&
                     (addr_ext < ({1'b0, BASE_ADDR} + 13'(NREG)));
  assign off       = addr - BASE_ADDR;
  assign wr_key    = wren && hit && (off == 12'd0);
  assign wr_status = wren && hit && (off == 12'd1);
  assign unused_wdata = ^wdata[31:8];

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = wr_key && not_empty;
  // A pop in the same cycle frees a slot, so a push at full still succeeds.
  assign push      = key_valid && (!full || pop);
  assign ovf_event = key_valid && full && !pop;
  assign head      = not_empty ? mem_q[rd_ptr_q] : 8'h00;

  assign frame_tick = sync3_q && !sync2_q;
  assign commit     = frame_tick && pend_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    frame_cnt_d = frame_cnt_q + {7'b0, frame_tick};
    shx_d       = shx_q;
    shy_d       = shy_q;
    shs_d       = shs_q;
    actx_d      = actx_q;
    acty_d      = acty_q;
    acts_d      = acts_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // Set wins over clear so an overflow in the clearing cycle is not lost.
    ovf_d  = (ovf_q && !(wr_status && wdata[1])) || ovf_event;
    pend_d = commit ? 1'b0 : pend_q;
    if (wr_status && wdata[0]) pend_d = 1'b1;
    // Copy sources are the pre-write shadows of this cycle.
    if (commit) begin
      actx_d = shx_q;
      acty_d = shy_q;
      acts_d = shs_q;
    end
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (wren && hit && off == 12'(2 + i))           shx_d[i] = wdata[COORD_W-1:0];
      if (wren && hit && off == 12'(2 + NUM_OBJ + i)) shy_d[i] = wdata[COORD_W-1:0];
    end
    if (wren && hit && off == 12'(2 + 2 * NUM_OBJ)) shs_d = wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      if (off == 12'd0)      rdata = {23'b0, not_empty, head};
      else if (off == 12'd1) rdata = {8'b0, 8'(count_q), ovf_q, pend_q, 6'b0, frame_cnt_q};
      else if (off == 12'(2 + 2 * NUM_OBJ)) rdata = {24'b0, shs_q};
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (off == 12'(2 + i))           rdata = 32'(shx_q[i]);
        if (off == 12'(2 + NUM_OBJ + i)) rdata = 32'(shy_q[i]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      shs_q       <= '0;
      acts_q      <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        shx_q[i]  <= COORD_W'(X_INIT);
        shy_q[i]  <= COORD_W'(Y_INIT);
        actx_q[i] <= COORD_W'(X_INIT);
        acty_q[i] <= COORD_W'(Y_INIT);
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sync1_q     <= vsync_n;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      shx_q       <= shx_d;
      shy_q       <= shy_d;
      shs_q       <= shs_d;
      actx_q      <= actx_d;
      acty_q      <= acty_d;
      acts_q      <= acts_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= key_data;
  end

  generate
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
      assign obj_x[gi*COORD_W +: COORD_W] = actx_q[gi];
      assign obj_y[gi*COORD_W +: COORD_W] = acty_q[gi];
    end
  endgenerate

  assign score = acts_q;

endmodule

// File: tb/tb_mmio_game_regs.sv
// Self-checking bench for mmio_game_regs: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue/array reference model.
module tb_mmio_game_regs;

  localparam int BASE = 2000;
  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int D    = 8;
  localparam int NREG = 3 + 2 * N;

  logic              clock = 1'b0;
  logic              reset;
  logic [11:0]       addr;
  logic [31:0]       wdata;
  logic              wren;
  logic [31:0]       rdata;
  logic              hit;
  logic              key_valid;
  logic [7:0]        key_data;
  logic              vsync_n;
  logic [N*CW-1:0]   obj_x, obj_y;
  logic [7:0]        score;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         sh_x [N], sh_y [N], ac_x [N], ac_y [N];
  int         sh_s, ac_s, pend, ovf, fc;
  logic [7:0] kq [$];
  int         hist [3];

  mmio_game_regs #(
    .BASE_ADDR(12'd2000), .NUM_OBJ(N), .COORD_W(CW),
    .X_INIT(315), .Y_INIT(235), .FIFO_DEPTH(D)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wren(wren),
    .rdata(rdata), .hit(hit), .key_valid(key_valid), .key_data(key_data),
    .vsync_n(vsync_n), .obj_x(obj_x), .obj_y(obj_y), .score(score)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 315; ac_x[i] = 315; sh_y[i] = 235; ac_y[i] = 235;
    end
    sh_s = 0; ac_s = 0; pend = 0; ovf = 0; fc = 0;
    kq.delete();
    hist = '{0, 0, 0};
  endfunction

  function automatic void model_step();
    int o, sz;
    bit wr_hit, popped, tick;
    o      = int'(addr) - BASE;
    wr_hit = wren && o >= 0 && o < NREG;
    sz     = kq.size();
    popped = wr_hit && o == 0 && sz > 0;
    // vsync falls between two samples; the tick acts on the edge after the synchroniser
    tick   = hist[2] == 1 && hist[1] == 0;
    if (tick && pend != 0) begin
      ac_x = sh_x; ac_y = sh_y; ac_s = sh_s; pend = 0;
    end
    if (wr_hit && o == 1 && wdata[0]) pend = 1;
    if (wr_hit && o == 1 && wdata[1]) ovf = 0;
    if (key_valid && sz == D && !popped) ovf = 1;
    if (popped) void'(kq.pop_front());
    if (key_valid && (sz < D || popped)) kq.push_back(key_data);
    if (tick) fc = (fc + 1) % 256;
    if (wr_hit && o >= 2 && o < 2 + N)          sh_x[o-2]   = int'(wdata % (32'd1 << CW));
    if (wr_hit && o >= 2 + N && o < 2 + 2 * N)  sh_y[o-2-N] = int'(wdata % (32'd1 << CW));
    if (wr_hit && o == 2 + 2 * N)               sh_s        = int'(wdata % 32'd256);
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(vsync_n);
  endfunction

  function automatic logic exp_hit(input logic [11:0] a);
    int o;
    o = int'(a) - BASE;
    return o >= 0 && o < NREG;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    int o;
    o = int'(a) - BASE;
    if (o < 0 || o >= NREG) return 32'h0;
    if (o == 0) return (kq.size() > 0) ? (32'h100 | 32'(kq[0])) : 32'h0;
    if (o == 1) return (32'(kq.size()) << 16) | (32'(ovf) << 15) | (32'(pend) << 14) | 32'(fc);
    if (o < 2 + N) return 32'(sh_x[o-2]);
    if (o < 2 + 2 * N) return 32'(sh_y[o-2-N]);
    return 32'(sh_s);
  endfunction

  function automatic logic [N*CW-1:0] exp_obj(input bit is_y);
    logic [N*CW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(is_y ? ac_y[i] : ac_x[i]);
    return r;
  endfunction

  always @(posedge clock) if (!reset) model_step();

  always @(negedge clock) begin
    chk("hit", 64'(hit), 64'(exp_hit(addr)));
    chk("rdata", 64'(rdata), 64'(exp_rd(addr)));
    chk("obj_x", 64'(obj_x), 64'(exp_obj(1'b0)));
    chk("obj_y", 64'(obj_y), 64'(exp_obj(1'b1)));
    chk("score", 64'(score), 64'(ac_s[7:0]));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input int o, input logic [31:0] d);
    addr = 12'(BASE + o); wdata = d; wren = 1'b1;
    cyc(1);
    wren = 1'b0; addr = 12'd0;
  endtask

  task automatic rdchk(input string nm, input int o, input logic [31:0] mask, input logic [31:0] exp);
    addr = 12'(BASE + o); wren = 1'b0;
    @(negedge clock);
    chk(nm, 64'(rdata & mask), 64'(exp));
    @(posedge clock);
    #1;
    addr = 12'd0;
  endtask

  task automatic objchk(input string nm, input int slot, input int exp);
    @(negedge clock);
    chk(nm, 64'(obj_x[slot*CW +: CW]), 64'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 12'd0; wdata = '0; wren = 1'b0;
    key_valid = 1'b0; key_data = 8'h00; vsync_n = 1'b1;
    model_reset();
    cyc(2);
    reset = 1'b0;

    // Reset state
    rdchk("reset_x0", 2, 32'hFFFF_FFFF, 32'd315);
    rdchk("reset_y0", 2 + N, 32'hFFFF_FFFF, 32'd235);
    rdchk("reset_status", 1, 32'hFFFF_FFFF, 32'd0);
    objchk("reset_objx0", 0, 315);

    // Shadow write is hidden until a frame tick follows the commit request
    cyc(3);
    wr(2, 32'd100);
    wr(1, 32'd1);
    cyc(4);
    objchk("held_objx0", 0, 315);
    rdchk("held_pending", 1, 32'h0000_4000, 32'h0000_4000);
    vsync_n = 1'b0;
    cyc(3);
    objchk("commit_objx0", 0, 100);
    rdchk("commit_pending_clr", 1, 32'h0000_40FF, 32'h0000_0001);
    vsync_n = 1'b1;

    // Overflow: nine keys into an eight-deep FIFO
    cyc(3);
    for (int k = 0; k < 9; k++) begin
      key_valid = 1'b1; key_data = 8'(8'h1C + k);
      cyc(1);
    end
    key_valid = 1'b0;
    rdchk("ovf_count", 1, 32'h00FF_0000, 32'h0008_0000);
    rdchk("ovf_flag", 1, 32'h0000_8000, 32'h0000_8000);
    for (int k = 0; k < 8; k++) begin
      rdchk("pop_head", 0, 32'h0000_01FF, 32'h100 | 32'(8'h1C + k));
      wr(0, 32'd0);
    end
    rdchk("drained", 0, 32'h0000_01FF, 32'h0);
    wr(1, 32'd2);
    rdchk("ovf_cleared", 1, 32'h0000_8000, 32'h0);

    // Push and pop together at full
    for (int k = 0; k < 8; k++) begin
      key_valid = 1'b1; key_data = 8'(8'h30 + k);
      cyc(1);
    end
    key_data = 8'h38; addr = 12'(BASE); wren = 1'b1;
    cyc(1);
    key_valid = 1'b0; wren = 1'b0;
    rdchk("full_pp_count", 1, 32'h00FF_8000, 32'h0008_0000);
    rdchk("full_pp_head", 0, 32'h0000_01FF, 32'h131);
    for (int k = 0; k < 7; k++) wr(0, 32'd0);
    rdchk("full_pp_newest", 0, 32'h0000_01FF, 32'h138);
    wr(0, 32'd0);

    // Commit request coincident with the frame tick is deferred
    wr(3, 32'd200);
    vsync_n = 1'b0;
    cyc(2);
    wr(1, 32'd1);
    vsync_n = 1'b1;
    objchk("defer_objx1", 1, 315);
    rdchk("defer_pending", 1, 32'h0000_4000, 32'h0000_4000);
    cyc(4);
    vsync_n = 1'b0;
    cyc(3);
    objchk("defer_commit_objx1", 1, 200);
    vsync_n = 1'b1;

    // Window boundaries
    for (int b = 0; b < 2; b++) begin
      int o;
      o = (b == 0) ? -1 : NREG;
      addr = 12'(BASE + o); wdata = 32'hFFFF_FFFF; wren = 1'b1;
      @(negedge clock);
      chk("oob_hit", 64'(hit), 64'd0);
      chk("oob_rdata", 64'(rdata), 64'd0);
      @(posedge clock);
      #1;
      wren = 1'b0;
    end
    rdchk("oob_x0_kept", 2, 32'hFFFF_FFFF, 32'd100);
    rdchk("oob_score_kept", 2 + 2 * N, 32'hFFFF_FFFF, 32'd0);
    rdchk("oob_status_kept", 1, 32'h00FF_C000, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        addr      = 12'(BASE - 2 + int'($urandom_range(0, NREG + 3)));
        wren      = ($urandom_range(0, 9) < 3);
        wdata     = $urandom;
        key_valid = ($urandom_range(0, 9) < 4);
        key_data  = 8'($urandom);
        if (vsync_n && $urandom_range(0, 14) == 0) vsync_n = 1'b0;
        else if (!vsync_n && $urandom_range(0, 2) == 0) vsync_n = 1'b1;
        cyc(1);
      end
    end
    wren = 1'b0; key_valid = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
